uart_ldpc_rx_framer: RTL and testbench

- 16x-oversampled UART receive front end for the (16,8) LDPC link.
- Frame format: 1 start bit, 16 codeword bits LSB-first, 1 stop bit.
- Delivers each validated 16-bit codeword to the downstream LDPC syndrome/correction stage through a valid/ready hold register.
- Replaces single-sample-per-bit reception with start-bit validation, mid-bit sampling, framing-error and overrun reporting.

---
 rtl/uart_ldpc_pkg.sv | 14 +
 rtl/uart_os_tick.sv | 32 +++
 rtl/uart_ldpc_rx_framer.sv | 151 +++++++++++++++
 tb/tb_uart_ldpc_rx_framer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_ldpc_pkg.sv
// rtl/uart_ldpc_pkg.sv - shared types and constants for the LDPC UART link
package uart_ldpc_pkg;

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} rx_state_e;

    localparam int CW_BITS  = 16;
    localparam int MSG_BITS = 8;

    // Nearest-integer clocks per oversample tick.
    function automatic int calc_div(input int clk_hz, input int baud, input int osr);
        return (clk_hz + (baud * osr) / 2) / (baud * osr);
    endfunction

endpackage

// File: rtl/uart_os_tick.sv
// rtl/uart_os_tick.sv - free-running oversample tick prescaler
module uart_os_tick
    import uart_ldpc_pkg::*;
#(
    parameter int DIV = 651
) (
    input  logic clk,
    input  logic rst_n,
    output logic os_tick
);

    localparam int              CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = (cnt_q == LAST) ? '0 : cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign os_tick = (cnt_q == LAST);

endmodule

// File: rtl/uart_ldpc_rx_framer.sv
// rtl/uart_ldpc_rx_framer.sv - oversampled UART receiver delivering 16-bit LDPC codewords
module uart_ldpc_rx_framer
    import uart_ldpc_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int BAUD      = 9600,
    parameter int OSR       = 16,
    parameter int DATA_BITS = CW_BITS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] cw_data,
    output logic                 cw_valid,
    input  logic                 cw_ready,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int               DIV       = calc_div(CLK_HZ, BAUD, OSR);
    localparam int               TICK_W    = $clog2(OSR);
    localparam int               BIT_W     = $clog2(DATA_BITS);
    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OSR / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OSR - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic                 os_tick;
    logic                 rx_meta_q, rx_s_q;
    rx_state_e            state_q, state_d;
    logic [TICK_W-1:0]    tick_cnt_q, tick_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] cw_data_q, cw_data_d;
    logic                 cw_valid_q, cw_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;

    uart_os_tick #(.DIV(DIV)) u_os_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .os_tick (os_tick)
    );

    always_comb begin
        state_d     = state_q;
        tick_cnt_d  = tick_cnt_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        cw_data_d   = cw_data_q;
        cw_valid_d  = cw_valid_q;
        frame_err_d = 1'b0;
        overrun_d   = 1'b0;

        if (cw_valid_q && cw_ready) begin
            cw_valid_d = 1'b0;
        end

        if (os_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rx_s_q) begin
                        state_d    = START;
                        tick_cnt_d = '0;
                    end
                end
                START: begin
                    if (tick_cnt_q == TICK_MID) begin
                        tick_cnt_d = '0;
                        bit_cnt_d  = '0;
                        state_d    = rx_s_q ? IDLE : DATA;
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        shift_d    = {rx_s_q, shift_q[DATA_BITS-1:1]};
                        if (bit_cnt_q == BIT_LAST) begin
                            bit_cnt_d = '0;
                            state_d   = STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + BIT_W'(1);
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_cnt_q == TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (!rx_s_q) begin
                            frame_err_d = 1'b1;
                            state_d     = BREAK;
                        end else if (cw_valid_q && !cw_ready) begin
                            overrun_d = 1'b1;
                            state_d   = IDLE;
                        end else begin
                            // A same-cycle accept frees the hold register, so the load wins.
                            cw_data_d  = shift_q;
                            cw_valid_d = 1'b1;
                            state_d    = IDLE;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + TICK_W'(1);
                    end
                end
                BREAK: begin
                    if (rx_s_q) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
            state_q     <= IDLE;
            tick_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            cw_data_q   <= '0;
            cw_valid_q  <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            rx_meta_q   <= rx;
            rx_s_q      <= rx_meta_q;
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            cw_data_q   <= cw_data_d;
            cw_valid_q  <= cw_valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

    assign cw_data   = cw_data_q;
    assign cw_valid  = cw_valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_ldpc_rx_framer.sv
// tb/tb_uart_ldpc_rx_framer.sv - directed self-checking bench for uart_ldpc_rx_framer
module tb_uart_ldpc_rx_framer;

    localparam int BIT_CLK   = 160;
    localparam int FRAME_CLK = 18 * BIT_CLK;
    localparam int STOP_TICK = 280;

    typedef struct {
        logic [15:0] word;
        logic [15:0] exp_data;
        int          exp_fe;
        int          exp_ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        cw_ready = 1'b0;
    logic [15:0] cw_data;
    logic        cw_valid;
    logic        frame_err;
    logic        overrun;
    logic        busy;

    int tests = 0;
    int fails = 0;
    int fe_cnt = 0;
    int ov_cnt = 0;
    int fe0, ov0;

    logic [3:0] m_cnt;
    logic       m_meta, m_rxs;

    vec_t vecs[4];

    always #5 clk = ~clk;

    uart_ldpc_rx_framer #(
        .CLK_HZ    (1_600_000),
        .BAUD      (10_000),
        .OSR       (16),
        .DATA_BITS (16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .cw_data   (cw_data),
        .cw_valid  (cw_valid),
        .cw_ready  (cw_ready),
        .frame_err (frame_err),
        .overrun   (overrun),
        .busy      (busy)
    );

    always @(posedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
    end

    // Reference prescaler and synchronizer, used only to time the simultaneous accept.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_cnt  <= 4'd0;
            m_meta <= 1'b1;
            m_rxs  <= 1'b1;
        end else begin
            m_cnt  <= (m_cnt == 4'd9) ? 4'd0 : m_cnt + 4'd1;
            m_meta <= rx;
            m_rxs  <= m_meta;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send(input logic [15:0] w, input logic stop, input int from, input int upto);
        logic [17:0] bits;
        bits = {stop, w, 1'b0};
        for (int k = from; k < upto; k++) begin
            rx = bits[k / BIT_CLK];
            @(negedge clk);
        end
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic accept_pulse(input string name);
        cw_ready = 1'b1;
        @(negedge clk);
        cw_ready = 1'b0;
        check({name, "_accepted"}, 32'(cw_valid), 32'd0);
    endtask

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{word: 16'hA5C3, exp_data: 16'hA5C3, exp_fe: 0, exp_ov: 0};
        vecs[1] = '{word: 16'h8001, exp_data: 16'h8001, exp_fe: 0, exp_ov: 0};
        vecs[2] = '{word: 16'h7FFE, exp_data: 16'h7FFE, exp_fe: 0, exp_ov: 0};
        vecs[3] = '{word: 16'h0000, exp_data: 16'h0000, exp_fe: 0, exp_ov: 0};

        repeat (3) @(negedge clk);
        check("rst_cw_valid", 32'(cw_valid), 32'd0);
        check("rst_cw_data", 32'(cw_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        rst_n = 1'b1;
        idle(50);

        for (int i = 0; i < 4; i++) begin
            fe0 = fe_cnt;
            ov0 = ov_cnt;
            send(vecs[i].word, 1'b1, 0, 2790);
            check($sformatf("v%0d_early_valid", i), 32'(cw_valid), 32'd0);
            send(vecs[i].word, 1'b1, 2790, FRAME_CLK);
            rx = 1'b1;
            check($sformatf("v%0d_valid", i), 32'(cw_valid), 32'd1);
            check($sformatf("v%0d_data", i), 32'(cw_data), 32'(vecs[i].exp_data));
            check($sformatf("v%0d_frame_err", i), 32'(fe_cnt - fe0), 32'(vecs[i].exp_fe));
            check($sformatf("v%0d_overrun", i), 32'(ov_cnt - ov0), 32'(vecs[i].exp_ov));
            accept_pulse($sformatf("v%0d", i));
            idle(100);
        end

        // Glitch shorter than half a bit.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        rx = 1'b0;
        repeat (30) @(negedge clk);
        check("glitch_busy_high", 32'(busy), 32'd1);
        repeat (10) @(negedge clk);
        idle(300);
        check("glitch_busy_low", 32'(busy), 32'd0);
        check("glitch_valid", 32'(cw_valid), 32'd0);
        check("glitch_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);

        // Framing error followed by a held-low line.
        fe0 = fe_cnt;
        send(16'h1234, 1'b0, 0, FRAME_CLK);
        rx = 1'b0;
        repeat (400) @(negedge clk);
        check("ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        check("ferr_valid", 32'(cw_valid), 32'd0);
        check("ferr_break_busy", 32'(busy), 32'd1);
        idle(50);
        check("ferr_idle", 32'(busy), 32'd0);
        send(16'h00FF, 1'b1, 0, FRAME_CLK);
        idle(20);
        check("after_ferr_valid", 32'(cw_valid), 32'd1);
        check("after_ferr_data", 32'(cw_data), 32'h00FF);
        check("after_ferr_pulses", 32'(fe_cnt - fe0), 32'd1);
        accept_pulse("after_ferr");
        idle(100);

        // Overrun: second frame dropped while the first is held.
        ov0 = ov_cnt;
        send(16'hBEEF, 1'b1, 0, FRAME_CLK);
        check("ovr_first_data", 32'(cw_data), 32'hBEEF);
        send(16'hCAFE, 1'b1, 0, FRAME_CLK);
        idle(20);
        check("ovr_pulses", 32'(ov_cnt - ov0), 32'd1);
        check("ovr_data_kept", 32'(cw_data), 32'hBEEF);
        check("ovr_valid_kept", 32'(cw_valid), 32'd1);
        accept_pulse("ovr");
        idle(100);

        // Accept of the held word coincides with the next load.
        ov0 = ov_cnt;
        send(16'hFFFF, 1'b1, 0, FRAME_CLK);
        check("sim_first_data", 32'(cw_data), 32'hFFFF);
        fork
            send(16'h0001, 1'b1, 0, FRAME_CLK);
            begin
                bit found;
                int t;
                found = 1'b0;
                for (int n = 0; n < 4000 && !found; n++) begin
                    @(negedge clk);
                    if (m_cnt == 4'd9 && !m_rxs) found = 1'b1;
                end
                check("sim_start_seen", 32'(found), 32'd1);
                t = 0;
                for (int n = 0; n < 4000 && t < STOP_TICK; n++) begin
                    @(negedge clk);
                    if (m_cnt == 4'd9) t++;
                end
                cw_ready = 1'b1;
                check("sim_held_before_load", 32'(cw_data), 32'hFFFF);
                @(negedge clk);
                check("sim_load_valid", 32'(cw_valid), 32'd1);
                check("sim_load_data", 32'(cw_data), 32'h0001);
                @(negedge clk);
                check("sim_second_accept", 32'(cw_valid), 32'd0);
            end
        join
        idle(50);
        cw_ready = 1'b0;
        check("sim_no_overrun", 32'(ov_cnt - ov0), 32'd0);
        check("sim_final_data", 32'(cw_data), 32'h0001);

        // Reset during data bit 7; the transmitter abandons the frame.
        fe0 = fe_cnt;
        ov0 = ov_cnt;
        send(16'h5555, 1'b1, 0, 8 * BIT_CLK + 80);
        check("rstmid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        rx = 1'b1;
        check("rstmid_data", 32'(cw_data), 32'd0);
        check("rstmid_valid", 32'(cw_valid), 32'd0);
        check("rstmid_busy", 32'(busy), 32'd0);
        idle(3000);
        check("rstmid_no_word", 32'(cw_valid), 32'd0);
        check("rstmid_no_pulses", 32'((fe_cnt - fe0) + (ov_cnt - ov0)), 32'd0);
        send(16'hAAAA, 1'b1, 0, FRAME_CLK);
        idle(20);
        check("rstmid_next_valid", 32'(cw_valid), 32'd1);
        check("rstmid_next_data", 32'(cw_data), 32'hAAAA);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
